// File: rtl/sha256_message_scheduler.sv
// SHA-256 message schedule generator: streams one (Wt, Kt) pair per accepted round
// of a 512-bit padded block, using a 16-word sliding window.
module sha256_message_scheduler #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [511:0]      block_i,
  input  logic              v_i,
  output logic              ready_o,
  output logic [WORD_W-1:0] Wt_o,
  output logic [WORD_W-1:0] Kt_o,
  output logic [5:0]        round_o,
  output logic              last_o,
  output logic              v_o,
  input  logic              yumi_i
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] w [16];
  logic [5:0]        round;
  logic [WORD_W-1:0] k_rom;
  logic [WORD_W-1:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Same recurrence for every round; words produced after round 47 simply go unused.
  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= S_IDLE;
      round <= '0;
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (v_i) begin
            for (int unsigned i = 0; i < 16; i++)
              w[i] <= block_i[511 - WORD_W*i -: WORD_W];
            round <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (yumi_i) begin
            for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
            if (round == 6'(ROUNDS - 1)) begin
              round <= '0;
              state <= S_IDLE;
            end else begin
              round <= round + 6'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    k_rom = '0;
    case (round)
      6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
      default: k_rom = '0;
    endcase
  end

  // Outputs decode only registered state, so v_i/yumi_i never reach them combinationally.
  assign v_o     = (state == S_RUN);
  assign ready_o = (state == S_IDLE);
  assign Wt_o    = v_o ? w[0] : '0;
  assign Kt_o    = v_o ? k_rom : '0;
  assign round_o = round;
  assign last_o  = v_o && (round == 6'(ROUNDS - 1));

endmodule

// File: tb/tb_sha256_message_scheduler.sv
// Self-checking bench for sha256_message_scheduler: golden "abc" table, random blocks
// against a full-array schedule model, stall/busy/back-to-back/reset sequences.
module tb_sha256_message_scheduler;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic [511:0] block_i = '0;
  logic         v_i = 1'b0;
  logic         ready_o;
  logic [31:0]  Wt_o;
  logic [31:0]  Kt_o;
  logic [5:0]   round_o;
  logic         last_o;
  logic         v_o;
  logic         yumi_i = 1'b0;

  sha256_message_scheduler #(.ROUNDS(64), .WORD_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .block_i(block_i), .v_i(v_i),
    .ready_o(ready_o), .Wt_o(Wt_o), .Kt_o(Kt_o), .round_o(round_o),
    .last_o(last_o), .v_o(v_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int unsigned round;
    logic [31:0] wt;
    logic [31:0] kt;
    logic        last;
    logic        chk_wt;
  } golden_t;

  golden_t      gold [$];
  logic [31:0]  mw [64];
  int           errors = 0;
  int           checks = 0;
  logic [511:0] abc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook W[0..63] array, independent of any sliding-window formulation.
  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) mw[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      mw[t] = (rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10)) + mw[t-7]
            + (rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3)) + mw[t-16];
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_v"}, 32'(v_o), 32'd0);
    chk({tag, "_last"}, 32'(last_o), 32'd0);
    chk({tag, "_wt"}, Wt_o, 32'd0);
    chk({tag, "_kt"}, Kt_o, 32'd0);
    chk({tag, "_round"}, 32'(round_o), 32'd0);
  endtask

  // Handshake a block, then walk its rounds checking every presented pair.
  task automatic run_block(input string tag, input logic [511:0] blk, input bit use_gold,
                           input bit rand_yumi, input int stall_round, input int stall_len,
                           input int busy_round, input bit hold_next, input logic [511:0] next_blk,
                           input int abort_round, input int exp_cycles);
    int  r, cyc, stall_left, busy_left;
    bit  done, y;
    build_model(blk);
    chk({tag, "_ready_entry"}, 32'(ready_o), 32'd1);
    block_i = blk;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
    cyc = 1; r = 0; done = 0; stall_left = stall_len; busy_left = 0;
    while (!done && cyc < 400) begin
      if (r == abort_round) begin
        yumi_i = 1'b0;
        #2 reset_i = 1'b0;
        #1 chk_idle({tag, "_abort"});
        #3 reset_i = 1'b1;
        step();
        chk_idle({tag, "_post_abort"});
        return;
      end
      chk($sformatf("%s_v_r%0d", tag, r), 32'(v_o), 32'd1);
      chk($sformatf("%s_ready_r%0d", tag, r), 32'(ready_o), 32'd0);
      chk($sformatf("%s_round_r%0d", tag, r), 32'(round_o), 32'(r));
      chk($sformatf("%s_wt_r%0d", tag, r), Wt_o, mw[r]);
      chk($sformatf("%s_kt_r%0d", tag, r), Kt_o, KTAB[r]);
      chk($sformatf("%s_last_r%0d", tag, r), 32'(last_o), 32'(r == 63));
      if (use_gold)
        foreach (gold[g])
          if (gold[g].round == r) begin
            if (gold[g].chk_wt) chk($sformatf("%s_gold_wt_r%0d", tag, r), Wt_o, gold[g].wt);
            chk($sformatf("%s_gold_kt_r%0d", tag, r), Kt_o, gold[g].kt);
            chk($sformatf("%s_gold_last_r%0d", tag, r), 32'(last_o), 32'(gold[g].last));
          end
      if (r == stall_round && stall_left > 0) begin
        y = 0;
        stall_left--;
      end else begin
        y = rand_yumi ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (r == busy_round && busy_left == 0) begin
        busy_left = 3;
        block_i = ~blk;
        v_i = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          v_i = 1'b0;
          block_i = blk;
        end
      end
      if (hold_next && r == 62) begin
        block_i = next_blk;
        v_i = 1'b1;
      end
      yumi_i = y;
      step();
      cyc++;
      if (y) begin
        if (r == 63) done = 1;
        else r++;
      end
    end
    yumi_i = 1'b0;
    if (!done) begin
      chk({tag, "_timeout"}, 32'(cyc), 32'd0);
      return;
    end
    chk({tag, "_end_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_end_v"}, 32'(v_o), 32'd0);
    chk({tag, "_end_round"}, 32'(round_o), 32'd0);
    chk({tag, "_end_wt"}, Wt_o, 32'd0);
    if (exp_cycles > 0) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
  endtask

  initial begin
    logic [511:0] blk_a, blk_b;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    gold.push_back('{round: 0,  wt: 32'h61626380, kt: 32'h428a2f98, last: 1'b0, chk_wt: 1'b1});
    gold.push_back('{round: 1,  wt: 32'h00000000, kt: 32'h71374491, last: 1'b0, chk_wt: 1'b1});
    gold.push_back('{round: 15, wt: 32'h00000018, kt: 32'hc19bf174, last: 1'b0, chk_wt: 1'b1});
    gold.push_back('{round: 16, wt: 32'h61626380, kt: 32'he49b69c1, last: 1'b0, chk_wt: 1'b1});
    gold.push_back('{round: 17, wt: 32'h000f0000, kt: 32'hefbe4786, last: 1'b0, chk_wt: 1'b1});
    gold.push_back('{round: 63, wt: 32'h00000000, kt: 32'hc67178f2, last: 1'b1, chk_wt: 1'b0});

    #3 reset_i = 1'b0;
    #1 chk_idle("reset_async");
    step();
    step();
    #2 reset_i = 1'b1;
    step();
    chk_idle("reset_release");

    yumi_i = 1'b1;
    repeat (3) step();
    yumi_i = 1'b0;
    chk_idle("idle_yumi");

    run_block("abc", abc, 1, 0, -1, 0, -1, 0, '0, -1, 65);
    run_block("stall", abc, 1, 0, 5, 3, -1, 0, '0, -1, 68);
    run_block("busy", abc, 1, 0, -1, 0, 30, 0, '0, -1, 65);

    blk_a = rand_block();
    blk_b = rand_block();
    run_block("b2b_a", blk_a, 0, 0, -1, 0, -1, 1, blk_b, -1, 65);
    run_block("b2b_b", blk_b, 0, 0, -1, 0, -1, 0, '0, -1, 65);

    for (int i = 0; i < 4; i++)
      run_block($sformatf("rand%0d", i), rand_block(), 0, 1, -1, 0, -1, 0, '0, -1, 0);

    run_block("abort", abc, 1, 0, -1, 0, -1, 0, '0, 40, 0);
    run_block("after_abort", abc, 1, 0, -1, 0, -1, 0, '0, -1, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
